image_loader: RTL and testbench
===============================

IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 Parameter: bitwidth, default 9, signed pixel width, matching the accelerator's image element width.
REQ-002 Port: clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 Port: rst, input, 1, synchronous active-high reset.
REQ-004 Port: pix_data, input, bitwidth, signed pixel sample, row-major order.
REQ-005 Port: pix_valid, input, 1, pix_data and pix_last are valid this cycle.
REQ-006 Port: pix_ready, output, 1, loader accepts a pixel this cycle; transfer occurs when pix_valid && pix_ready.
REQ-007 Port: pix_last, input, 1, sender marks the final pixel of a frame.
REQ-008 Port: image, output, [27:0][27:0] x bitwidth signed, assembled frame, indexed image[row][col]; drives the accelerator image input.
REQ-009 Port: image_valid, output, 1, image holds a complete frame and is stable.
REQ-010 Port: image_consume, input, 1, one-cycle pulse from the downstream side releasing the held frame.
REQ-011 Port: frame_error, output, 1, one-cycle pulse on a pix_last framing mismatch.
REQ-012 Port: frame_count, output, 8, completed frames, wraps 255->0.

Function
REQ-013 The FSM SHALL have two states: LOAD and HOLD.
REQ-014 pix_ready SHALL equal (state==LOAD) && !rst; image_valid SHALL equal (state==HOLD).
REQ-015 In LOAD, each accepted pixel SHALL be written to image[row][col], then col SHALL increment, and at col==27 col SHALL wrap to 0 with row incrementing.
REQ-016 Accepting the pixel at row==27, col==27 (784th pixel) SHALL move the FSM to HOLD on the next cycle, zero row/col, and increment frame_count.
REQ-017 If the 784th pixel arrives with pix_last==0, the frame SHALL still complete and frame_error SHALL pulse in the following cycle.
REQ-018 If pix_last==1 on an accepted pixel other than the 784th, that pixel SHALL be written, row/col SHALL reset to 0, the FSM SHALL stay in LOAD, frame_count SHALL be unchanged, and frame_error SHALL pulse in the following cycle.
REQ-019 In HOLD, the image contents SHALL NOT change and pix_ready SHALL be 0.
REQ-020 In HOLD, image_consume==1 SHALL return the FSM to LOAD on the next cycle, so pix_ready is 1 one cycle after the pulse.
REQ-021 image_consume SHALL be ignored in LOAD.
REQ-022 Pixels presented while pix_ready==0 SHALL be neither written nor counted.
REQ-023 Latency from the 784th accept edge to image_valid==1 SHALL be 1 cycle.
REQ-024 frame_error SHALL be registered and SHALL be high for exactly 1 cycle per error.

Reset
REQ-025 While rst==1, the loader SHALL set state=LOAD, row=col=0, frame_count=0, frame_error=0, every image element=0, and pix_ready=0.
REQ-026 Reset asserted mid-frame or in HOLD SHALL discard the partial or held frame.
REQ-027 After rst deasserts, pix_ready SHALL be 1 in the first cycle.

Verification
REQ-028 Scenario: stream 784 pixels with value (row+col)%128, pix_valid held high and pix_last only on the last pixel -> image_valid=1 one cycle after the last accept, image[r][c]==(r+c)%128 for all r,c, frame_count=1, frame_error never 1.
REQ-029 Scenario: random pix_valid gaps with 30% idle cycles during a frame -> same final image as the gap-free run; no pixel lost or duplicated.
REQ-030 Scenario: pix_last on pixel 100 -> frame_error pulses for 1 cycle, image_valid=0, frame_count=0; the next 784-pixel frame completes normally.
REQ-031 Scenario: 784 pixels with pix_last=0 throughout -> image_valid=1 and frame_error pulses once.
REQ-032 Scenario: in HOLD, drive pix_valid=1 with pix_data=-5 for 10 cycles, then pulse image_consume -> image unchanged during HOLD, pix_ready=1 one cycle after the pulse, next frame overwrites from image[0][0].
REQ-033 Scenario: assert rst after pixel 400, and separately assert rst during HOLD -> all image elements 0, image_valid=0, frame_count=0, pix_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/image_loader.sv
// Pixel-stream to frame loader: assembles a 28x28 signed image in row-major order,
// holds it for the accelerator until the downstream side consumes it.
module image_loader #(
    parameter int bitwidth = 9
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic signed [bitwidth-1:0]                pix_data,
    input  logic                                      pix_valid,
    output logic                                      pix_ready,
    input  logic                                      pix_last,
    output logic signed [27:0][27:0][bitwidth-1:0]    image,
    output logic                                      image_valid,
    input  logic                                      image_consume,
    output logic                                      frame_error,
    output logic [7:0]                                frame_count
);

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                                  r_state;
    logic [4:0]                              r_row;
    logic [4:0]                              r_col;
    logic signed [27:0][27:0][bitwidth-1:0]  r_image;
    logic                                    r_frame_error;
    logic [7:0]                              r_frame_count;

    logic                                    w_accept;
    logic                                    w_frame_end;

    assign pix_ready   = (r_state == LOAD) && !rst;
    assign w_accept    = pix_valid && pix_ready;
    assign w_frame_end = (r_row == 5'd27) && (r_col == 5'd27);

    assign image       = r_image;
    assign image_valid = (r_state == HOLD);
    assign frame_error = r_frame_error;
    assign frame_count = r_frame_count;

    // Frame assembly FSM: write position, frame hand-off and framing-error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= LOAD;
            r_row         <= 5'd0;
            r_col         <= 5'd0;
            r_image       <= '0;
            r_frame_error <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_frame_error <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        r_image[r_row][r_col] <= pix_data;
                        if (w_frame_end) begin
                            // A full frame completes even if the sender forgot pix_last
                            r_state       <= HOLD;
                            r_row         <= 5'd0;
                            r_col         <= 5'd0;
                            r_frame_count <= r_frame_count + 8'd1;
                            r_frame_error <= !pix_last;
                        end else if (pix_last) begin
                            r_row         <= 5'd0;
                            r_col         <= 5'd0;
                            r_frame_error <= 1'b1;
                        end else if (r_col == 5'd27) begin
                            r_col <= 5'd0;
                            r_row <= r_row + 5'd1;
                        end else begin
                            r_col <= r_col + 5'd1;
                        end
                    end
                end
                HOLD: begin
                    if (image_consume) begin
                        r_state <= LOAD;
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader: table vectors, directed frame scenarios
// and randomized traffic against a linear-index frame model.
module tb_image_loader;

    logic                           clk;
    logic                           rst;
    logic signed [8:0]              pix_data;
    logic                           pix_valid;
    logic                           pix_ready;
    logic                           pix_last;
    logic signed [27:0][27:0][8:0]  image;
    logic                           image_valid;
    logic                           image_consume;
    logic                           frame_error;
    logic [7:0]                     frame_count;

    image_loader #(.bitwidth(9)) dut (
        .clk           (clk),
        .rst           (rst),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_last      (pix_last),
        .image         (image),
        .image_valid   (image_valid),
        .image_consume (image_consume),
        .frame_error   (frame_error),
        .frame_count   (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame as a flat 784-entry array filled by a linear pixel index
    logic [8:0] m_img [784];
    int         m_idx;
    bit         m_hold;
    int         m_cnt;
    bit         m_err;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [8:0] data;
        logic       last;
        logic       consume;
        logic       e_ready;
        logic       e_valid;
        logic       e_err;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [8:0] d,
                              input logic l, input logic c);
        if (r) begin
            m_hold = 1'b0;
            m_idx  = 0;
            m_cnt  = 0;
            m_err  = 1'b0;
            for (int i = 0; i < 784; i++) m_img[i] = 9'd0;
        end else begin
            m_err = 1'b0;
            if (!m_hold) begin
                if (v) begin
                    m_img[m_idx] = d;
                    if (m_idx == 783) begin
                        m_hold = 1'b1;
                        m_idx  = 0;
                        m_cnt  = (m_cnt + 1) % 256;
                        m_err  = !l;
                    end else if (l) begin
                        m_idx = 0;
                        m_err = 1'b1;
                    end else begin
                        m_idx = m_idx + 1;
                    end
                end
            end else if (c) begin
                m_hold = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive, check ready before the edge, update model, check after
    task automatic cyc(input logic r, input logic v, input logic [8:0] d,
                       input logic l, input logic c, output logic rdy_seen);
        rst           = r;
        pix_valid     = v;
        pix_data      = d;
        pix_last      = l;
        image_consume = c;
        #1;
        rdy_seen = pix_ready;
        chk("pix_ready", {31'd0, pix_ready}, {31'd0, (!m_hold && !r)});
        @(posedge clk);
        model_step(r, v, d, l, c);
        #1;
        chk("image_valid", {31'd0, image_valid}, {31'd0, m_hold});
        chk("frame_error", {31'd0, frame_error}, {31'd0, m_err});
        chk("frame_count", {24'd0, frame_count}, m_cnt);
    endtask

    task automatic check_image(input string name);
        int bad;
        int fr;
        int fc;
        bad = 0;
        fr  = 0;
        fc  = 0;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                if (image[r][c] !== m_img[r*28+c]) begin
                    if (bad == 0) begin fr = r; fc = c; end
                    bad++;
                end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: %0d elements differ, first [%0d][%0d] got %0d expected %0d",
                     name, bad, fr, fc, image[fr][fc], m_img[fr*28+fc]);
        end
    endtask

    task automatic check_pattern(input string name);
        int bad;
        logic [8:0] want;
        bad = 0;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) begin
                want = 9'((r + c) % 128);
                if (image[r][c] !== want) bad++;
            end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: %0d elements differ from (r+c)%%128, required 0", name, bad);
        end
    endtask

    task automatic check_zero(input string name);
        int bad;
        bad = 0;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                if (image[r][c] !== 9'd0) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: %0d nonzero elements, required 0", name, bad);
        end
    endtask

    // Send pixels 0..n-1; last_at marks pix_last (-1: never). Idle cycles carry junk.
    task automatic send_frame(input int n, input bit patterned, input int gap_pct, input int last_at);
        logic       rdy;
        logic [8:0] d;
        int         r;
        int         c;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct)
                cyc(1'b0, 1'b0, 9'($urandom), 1'($urandom), 1'($urandom), rdy);
            r = i / 28;
            c = i % 28;
            d = patterned ? 9'((r + c) % 128) : 9'($urandom);
            cyc(1'b0, 1'b1, d, (i == last_at), 1'b0, rdy);
        end
    endtask

    task automatic hold_and_consume(input int n, input logic [8:0] d);
        logic rdy;
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, d, 1'b0, 1'b0, rdy);
            check_image("hold_stable");
        end
        cyc(1'b0, 1'b0, d, 1'b0, 1'b1, rdy);
    endtask

    initial begin
        logic rdy;
        rst = 1'b1; pix_valid = 1'b0; pix_data = 9'd0; pix_last = 1'b0; image_consume = 1'b0;
        for (int i = 0; i < 784; i++) m_img[i] = 9'd0;
        m_idx = 0; m_hold = 1'b0; m_cnt = 0; m_err = 1'b0;

        tbl[0] = '{1'b1, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 1'b1, 9'd7,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 1'b1, 9'd3,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[3] = '{1'b0, 1'b0, 9'd9,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[4] = '{1'b0, 1'b1, 9'h1FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        tbl[5] = '{1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};

        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].rst, tbl[i].valid, tbl[i].data, tbl[i].last, tbl[i].consume, rdy);
            chk($sformatf("tbl%0d_ready", i), {31'd0, rdy}, {31'd0, tbl[i].e_ready});
            chk($sformatf("tbl%0d_valid", i), {31'd0, image_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_err", i), {31'd0, frame_error}, {31'd0, tbl[i].e_err});
            chk($sformatf("tbl%0d_cnt", i), {24'd0, frame_count}, {24'd0, tbl[i].e_cnt});
        end
        chk("tbl_pix00", {23'd0, image[0][0]}, 32'd3);
        chk("tbl_pix01", {23'd0, image[0][1]}, 32'h1FF);
        check_image("tbl_image");

        // Clean restart, gap-free patterned frame
        cyc(1'b1, 1'b0, 9'd0, 1'b0, 1'b0, rdy);
        cyc(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, rdy);
        chk("after_reset_ready", {31'd0, rdy}, 32'd1);
        send_frame(784, 1'b1, 0, 783);
        chk("frame1_valid", {31'd0, image_valid}, 32'd1);
        chk("frame1_count", {24'd0, frame_count}, 32'd1);
        check_pattern("frame1_pattern");

        // HOLD with junk pixels, then consume; pix_ready checked in the next cycle
        hold_and_consume(10, 9'h1FB);
        check_pattern("hold_unchanged");
        cyc(1'b0, 1'b1, 9'd77, 1'b0, 1'b0, rdy);
        chk("consume_ready", {31'd0, rdy}, 32'd1);
        chk("overwrite_00", {23'd0, image[0][0]}, 32'd77);

        // Finish that frame randomly, consume, then gapped patterned frame
        send_frame(783, 1'b0, 20, 782);
        check_image("frame2_image");
        hold_and_consume(2, 9'd5);
        send_frame(784, 1'b1, 30, 783);
        check_pattern("gapped_pattern");
        chk("gapped_count", {24'd0, frame_count}, 32'd3);
        hold_and_consume(1, 9'd0);

        // Early pix_last on pixel 100, then a normal frame
        send_frame(100, 1'b0, 10, 99);
        chk("early_last_valid", {31'd0, image_valid}, 32'd0);
        chk("early_last_err", {31'd0, frame_error}, 32'd1);
        cyc(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, rdy);
        chk("early_last_err_gone", {31'd0, frame_error}, 32'd0);
        send_frame(784, 1'b0, 10, 783);
        check_image("after_early_last");
        chk("after_early_count", {24'd0, frame_count}, 32'd4);
        hold_and_consume(1, 9'd0);

        // Missing pix_last: frame completes with an error pulse
        send_frame(784, 1'b0, 0, -1);
        chk("nolast_valid", {31'd0, image_valid}, 32'd1);
        chk("nolast_err", {31'd0, frame_error}, 32'd1);
        cyc(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, rdy);
        chk("nolast_err_once", {31'd0, frame_error}, 32'd0);
        hold_and_consume(1, 9'd0);

        // Reset mid-frame, then reset during HOLD
        send_frame(400, 1'b0, 10, -1);
        cyc(1'b1, 1'b1, 9'd1, 1'b0, 1'b0, rdy);
        check_zero("rst_midframe_zero");
        chk("rst_midframe_count", {24'd0, frame_count}, 32'd0);
        cyc(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, rdy);
        chk("rst_mid_release_ready", {31'd0, rdy}, 32'd1);
        send_frame(784, 1'b0, 0, 783);
        chk("pre_hold_rst_valid", {31'd0, image_valid}, 32'd1);
        cyc(1'b1, 1'b0, 9'd0, 1'b0, 1'b0, rdy);
        check_zero("rst_hold_zero");
        chk("rst_hold_valid", {31'd0, image_valid}, 32'd0);
        cyc(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, rdy);
        chk("rst_hold_release_ready", {31'd0, rdy}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            cyc(($urandom_range(999) == 0), ($urandom_range(99) < 70), 9'($urandom),
                ($urandom_range(299) == 0), ($urandom_range(99) < 5), rdy);
            if (i % 50 == 0) check_image("random_image");
        end
        check_image("final_image");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
